// File: rtl/uv_echo_responder.sv
// uv_echo_responder
//   Echo-generating end of the ultrasonic trigger/echo protocol. It accepts a
//   trigger pulse of at least MIN_TRIG cycles and waits BURST_DELAY cycles.
//   It then drives an echo whose width is dist_q*CYC_PER_MM cycles, or
//   TIMEOUT cycles when the target is out of range. A HOLDOFF dead time
//   follows before the next trigger is accepted.
//
// Ports
//   clk_50M      system clock
//   rst_n        asynchronous active-low reset
//   UV_trig      trigger from the sensor driver (asynchronous, synchronized here)
//   distance_mm  target distance in mm, sampled at trigger acceptance
//   UV_echo      echo pulse to the sensor driver
//   busy         high in DELAY, ECHO and HOLDOFF
//   trig_err     one-cycle pulse after a too-short trigger
//   meas_done    one-cycle pulse on the first cycle after echo falls
module uv_echo_responder #(
  parameter int MIN_TRIG    = 500,
  parameter int BURST_DELAY = 23000,
  parameter int CYC_PER_MM  = 292,
  parameter int MAX_MM      = 4000,
  parameter int TIMEOUT     = 1900000,
  parameter int HOLDOFF     = 50000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        UV_trig,
  input  logic [11:0] distance_mm,
  output logic        UV_echo,
  output logic        busy,
  output logic        trig_err,
  output logic        meas_done
);

  localparam int CW = 22;
  localparam int TW = $clog2(MIN_TRIG + 1);

  typedef enum logic [2:0] {IDLE, TRIG, DELAY, ECHO, HOLDOFF_ST} state_t;

  state_t          state, state_nx;
  logic            sync1, trig_s, trig_d;
  logic [TW-1:0]   trig_cnt, trig_cnt_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   echo_len, echo_len_nx, echo_calc;
  logic [11:0]     dist_q, dist_nx, dist_eff;
  logic            trig_err_nx, meas_done_nx;

  // Two-flop synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      sync1  <= UV_trig;
      trig_s <= sync1;
      trig_d <= trig_s;
    end
  end

  // Echo width from the latched distance. A zero distance counts as 1 mm.
  // The 22-bit product holds 4095*292 without overflow.
  always_comb begin
    dist_eff = (dist_q == 12'd0) ? 12'd1 : dist_q;
    if (int'(dist_q) > MAX_MM)
      echo_calc = CW'(TIMEOUT);
    else
      echo_calc = CW'(dist_eff) * CW'(CYC_PER_MM);
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    trig_cnt_nx  = trig_cnt;
    dist_nx      = dist_q;
    echo_len_nx  = echo_len;
    trig_err_nx  = 1'b0;
    meas_done_nx = 1'b0;
    case (state)
      IDLE: begin
        // Only a fresh rising edge starts a trigger. A level already high is ignored.
        if (trig_s && !trig_d) begin
          state_nx    = TRIG;
          trig_cnt_nx = TW'(1);
        end
      end
      TRIG: begin
        if (trig_s) begin
          if (trig_cnt < TW'(MIN_TRIG)) trig_cnt_nx = trig_cnt + TW'(1);
        end else if (trig_cnt >= TW'(MIN_TRIG)) begin
          dist_nx     = distance_mm;
          cnt_nx      = '0;
          trig_cnt_nx = '0;
          state_nx    = DELAY;
        end else begin
          trig_err_nx = 1'b1;
          trig_cnt_nx = '0;
          state_nx    = IDLE;
        end
      end
      DELAY: begin
        if (cnt == CW'(BURST_DELAY - 1)) begin
          cnt_nx      = '0;
          echo_len_nx = echo_calc;
          state_nx    = ECHO;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ECHO: begin
        if (cnt == echo_len - CW'(1)) begin
          cnt_nx       = '0;
          meas_done_nx = 1'b1;
          state_nx     = HOLDOFF_ST;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HOLDOFF_ST: begin
        if (cnt == CW'(HOLDOFF - 1)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so that they change on the
  // same edge as the state. Reset clears them asynchronously.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      trig_cnt  <= '0;
      dist_q    <= '0;
      echo_len  <= '0;
      UV_echo   <= 1'b0;
      busy      <= 1'b0;
      trig_err  <= 1'b0;
      meas_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      trig_cnt  <= trig_cnt_nx;
      dist_q    <= dist_nx;
      echo_len  <= echo_len_nx;
      UV_echo   <= (state_nx == ECHO);
      busy      <= (state_nx == DELAY) || (state_nx == ECHO) || (state_nx == HOLDOFF_ST);
      trig_err  <= trig_err_nx;
      meas_done <= meas_done_nx;
    end
  end

endmodule

// File: tb/tb_uv_echo_responder.sv
// Bench for uv_echo_responder. It uses scaled-down timing parameters so that
// every scenario, including the out-of-range timeout, stays short. Expected
// echoes (rise cycle and width) go into a queue when a trigger is driven. A
// passive monitor records observed echoes, and each test task pops and
// compares them.
module tb_uv_echo_responder;
  localparam int MIN_TRIG    = 20;
  localparam int BURST_DELAY = 100;
  localparam int CYC_PER_MM  = 3;
  localparam int MAX_MM      = 4000;
  localparam int TIMEOUT     = 15000;
  localparam int HOLDOFF     = 200;
  localparam int BUDGET      = 40000;

  typedef struct {int rise; int width;} exp_t;
  typedef struct {int rise; int width; logic md;} obs_t;

  logic        clk_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic        UV_trig = 1'b0;
  logic [11:0] distance_mm = '0;
  logic        UV_echo, busy, trig_err, meas_done;

  always #10 clk_50M = ~clk_50M;

  uv_echo_responder #(
    .MIN_TRIG(MIN_TRIG), .BURST_DELAY(BURST_DELAY), .CYC_PER_MM(CYC_PER_MM),
    .MAX_MM(MAX_MM), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .UV_trig(UV_trig), .distance_mm(distance_mm),
    .UV_echo(UV_echo), .busy(busy), .trig_err(trig_err), .meas_done(meas_done)
  );

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // Passive monitor
  obs_t obs_q[$];
  exp_t exp_q[$];
  logic prev_echo = 1'b0, prev_busy = 1'b0;
  int   rise_c = 0, w = 0, te_cnt = 0, te_run = 0, te_max = 0, md_cnt = 0, busy_fall = 0;

  always @(negedge clk_50M) begin
    if (UV_echo && !prev_echo) begin
      rise_c <= cyc;
      w      <= 1;
    end else if (UV_echo) begin
      w <= w + 1;
    end
    if (!UV_echo && prev_echo) obs_q.push_back('{rise_c, w, meas_done});
    if (trig_err) begin
      te_cnt <= te_cnt + 1;
      te_run <= te_run + 1;
      if (te_run + 1 > te_max) te_max <= te_run + 1;
    end else begin
      te_run <= 0;
    end
    if (meas_done) md_cnt <= md_cnt + 1;
    if (!busy && prev_busy) busy_fall <= cyc;
    prev_echo <= UV_echo;
    prev_busy <= busy;
  end

  int n_chk = 0, n_fail = 0;

  function automatic int exp_w(input int d);
    if (d > MAX_MM) return TIMEOUT;
    return ((d == 0) ? 1 : d) * CYC_PER_MM;
  endfunction

  task automatic pulse_trig(input int len, output int drop);
    @(posedge clk_50M); #1 UV_trig = 1'b1;
    repeat (len) @(posedge clk_50M);
    #1 UV_trig = 1'b0;
    drop = cyc;
  endtask

  // Valid trigger. The echo rises BURST_DELAY+1 cycles after the first trig_s-low cycle (drop+2).
  task automatic send(input int d, output int drop);
    distance_mm = 12'(d);
    pulse_trig(MIN_TRIG, drop);
    exp_q.push_back('{drop + 3 + BURST_DELAY, exp_w(d)});
  endtask

  task automatic check_echo(input string name);
    int n;
    obs_t o;
    exp_t e;
    n = 0;
    while (obs_q.size() == 0 && n < BUDGET) begin @(negedge clk_50M); n++; end
    n_chk++;
    if (obs_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no echo within %0d cycles", name, BUDGET);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      return;
    end
    o = obs_q.pop_front();
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected echo width %0d at cycle %0d", name, o.width, o.rise);
      return;
    end
    e = exp_q.pop_front();
    if (o.rise !== e.rise) begin
      n_fail++; $display("FAIL %s rise: got cycle %0d want %0d", name, o.rise, e.rise);
    end
    n_chk++;
    if (o.width !== e.width) begin
      n_fail++; $display("FAIL %s width: got %0d want %0d", name, o.width, e.width);
    end
    n_chk++;
    if (o.md !== 1'b1) begin
      n_fail++; $display("FAIL %s meas_done: got %b want 1", name, o.md);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < BUDGET) begin @(negedge clk_50M); n++; end
    @(negedge clk_50M);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s idle: busy=%b after %0d cycles want 0", name, busy, BUDGET);
    end
  endtask

  task automatic wait_echo_high(input string name);
    int n;
    n = 0;
    while (UV_echo !== 1'b1 && n < BUDGET) begin @(negedge clk_50M); n++; end
    n_chk++;
    if (UV_echo !== 1'b1) begin
      n_fail++; $display("FAIL %s echo rise: UV_echo=%b want 1", name, UV_echo);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50M);
    n_chk++; if (UV_echo !== 1'b0)   begin n_fail++; $display("FAIL reset UV_echo: got %b want 0", UV_echo); end
    n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_chk++; if (trig_err !== 1'b0)  begin n_fail++; $display("FAIL reset trig_err: got %b want 0", trig_err); end
    n_chk++; if (meas_done !== 1'b0) begin n_fail++; $display("FAIL reset meas_done: got %b want 0", meas_done); end
    @(posedge clk_50M); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post-reset busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int drop, md0;
    md0 = md_cnt;
    send(62, drop);
    repeat (5) @(posedge clk_50M);
    distance_mm = 12'd999;  // must not affect the echo in flight
    @(negedge clk_50M);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic busy in delay: got %b want 1", busy); end
    check_echo("basic_62mm");
    wait_idle("basic");
    n_chk++;
    if (busy_fall !== drop + 3 + BURST_DELAY + exp_w(62) + HOLDOFF) begin
      n_fail++; $display("FAIL basic turnaround: busy fell at %0d want %0d", busy_fall,
                         drop + 3 + BURST_DELAY + exp_w(62) + HOLDOFF);
    end
    n_chk++;
    if (md_cnt - md0 !== 1) begin
      n_fail++; $display("FAIL basic meas_done count: got %0d want 1", md_cnt - md0);
    end
  endtask

  task automatic test_distances();
    int dist_tab[4] = '{31, 0, 4001, 4000};
    int drop;
    foreach (dist_tab[i]) begin
      send(dist_tab[i], drop);
      check_echo($sformatf("dist_%0d", dist_tab[i]));
      wait_idle("dist");
    end
  endtask

  task automatic test_short_trig();
    int drop, te0;
    logic busy_seen;
    te0 = te_cnt;
    busy_seen = 1'b0;
    pulse_trig(MIN_TRIG - 1, drop);
    repeat (10) begin @(negedge clk_50M); if (busy) busy_seen = 1'b1; end
    n_chk++; if (te_cnt - te0 !== 1) begin n_fail++; $display("FAIL short trig_err count: got %0d want 1", te_cnt - te0); end
    n_chk++; if (te_max !== 1) begin n_fail++; $display("FAIL short trig_err width: got %0d want 1", te_max); end
    n_chk++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL short busy: got %b want 0", busy_seen); end
    n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL short echo count: got %0d want 0", obs_q.size()); end
    send(31, drop);
    check_echo("after_short");
    wait_idle("after_short");
  endtask

  task automatic test_ignored();
    int drop, dummy, te0;
    te0 = te_cnt;
    send(100, drop);
    wait_echo_high("ignored");
    repeat (50) @(posedge clk_50M);
    pulse_trig(MIN_TRIG, dummy);      // during ECHO
    check_echo("ignored_echo");
    pulse_trig(MIN_TRIG, dummy);      // during HOLDOFF
    wait_idle("ignored");
    repeat (30) @(negedge clk_50M);
    n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL ignored extra echoes: got %0d want 0", obs_q.size()); end
    n_chk++; if (te_cnt !== te0) begin n_fail++; $display("FAIL ignored trig_err: got %0d pulses want 0", te_cnt - te0); end
    // Trigger held high through the end of HOLDOFF must not start a measurement.
    send(100, drop);
    wait_echo_high("held");
    #1 UV_trig = 1'b1;
    check_echo("held_echo");
    wait_idle("held");
    repeat (50) @(negedge clk_50M);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held busy: got %b want 0", busy); end
    n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL held echo count: got %0d want 0", obs_q.size()); end
    UV_trig = 1'b0;
    repeat (5) @(posedge clk_50M);
    send(100, drop);
    check_echo("after_held");
    wait_idle("after_held");
  endtask

  task automatic test_reset_mid_echo();
    int drop;
    obs_t o;
    send(100, drop);
    wait_echo_high("rst_mid");
    repeat (100) @(posedge clk_50M);
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (UV_echo !== 1'b0)   begin n_fail++; $display("FAIL rst_mid UV_echo: got %b want 0", UV_echo); end
    n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    n_chk++; if (meas_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid meas_done: got %b want 0", meas_done); end
    repeat (3) @(posedge clk_50M);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk_50M);
    while (obs_q.size() != 0) o = obs_q.pop_front();
    exp_q.delete();
    send(100, drop);
    check_echo("after_rst_mid");
    wait_idle("after_rst_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_distances();
    test_short_trig();
    test_ignored();
    test_reset_mid_echo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
